// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle HI/LO multiply/divide responder for the EX stage.
// Accepts mult/div/mthi/mtlo requests, holds the architectural HI/LO pair and
// reports Busy/StallReq so ID can hold mfhi/mflo behind a running operation.
// Optional feature: define MULDIV_MADD_EN to accept MADD/MADDU/MSUB/MSUBU
// (ops 6-9), which accumulate into {HI,LO} with multiply latency.
module muldiv_unit #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic [3:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic        StallReq,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MTHI  = 4'd4;
  localparam logic [3:0] OP_MTLO  = 4'd5;
`ifdef MULDIV_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd6;
  localparam logic [3:0] OP_MADDU = 4'd7;
  localparam logic [3:0] OP_MSUB  = 4'd8;
  localparam logic [3:0] OP_MSUBU = 4'd9;
`endif

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic [3:0]  op_q;
  logic [31:0] a_q, b_q;
  logic        is_mul, is_div, accept, commit;
  logic [63:0] prod_s, prod_u, res;

  // Decode the incoming request into latency class; unknown ops are neither.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    is_mul = 1'b0;
    is_div = 1'b0;
    case (Op)
      OP_MULT, OP_MULTU: is_mul = 1'b1;
      OP_DIV, OP_DIVU:   is_div = 1'b1;
`ifdef MULDIV_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: is_mul = 1'b1;
`endif
      default: ;
    endcase
  end

  assign accept = (state == S_IDLE) && Start && (is_mul || is_div);
  assign commit = (state == S_RUN) && (cnt == 5'd1);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: IDLE -> RUN on accept, RUN -> IDLE on the commit edge.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_RUN;
      S_RUN:   if (commit) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs: Busy mirrors the RUN state flop; StallReq also covers the accepting cycle.
  always_comb begin
    Busy     = (state == S_RUN);
    StallReq = Busy | (Start & (is_mul | is_div));
  end

  // Busy-cycle down-counter: loaded on accept, counts down through RUN to 0.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)                 cnt <= 5'd0;
    else if (accept)         cnt <= is_mul ? 5'(MUL_CYCLES) : 5'(DIV_CYCLES);
    else if (state == S_RUN) cnt <= cnt - 5'd1;
  end

  // Operand and opcode latch, captured only at acceptance.
  // NOTE: no reset here; these are only read in RUN, which is entered after a load.
  always_ff @(posedge Clk) begin
    if (accept) begin
      op_q <= Op;
      a_q  <= A;
      b_q  <= B;
    end
  end

  // Signed product via sign extension to 64 bits; the low 64 bits are exact.
  assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};

  // Result selection for the latched op; {HI,LO} here are still the values at acceptance.
  always_comb begin
    res = {HI, LO};
    case (op_q)
      OP_MULT:  res = prod_s;
      OP_MULTU: res = prod_u;
      OP_DIV: begin
        if (b_q == 32'd0)
          res = {a_q, 32'hFFFF_FFFF};
        else if (a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF)
          res = {32'd0, 32'h8000_0000};
        else
          res = {32'($signed(a_q) % $signed(b_q)), 32'($signed(a_q) / $signed(b_q))};
      end
      OP_DIVU: begin
        if (b_q == 32'd0) res = {a_q, 32'hFFFF_FFFF};
        else              res = {a_q % b_q, a_q / b_q};
      end
`ifdef MULDIV_MADD_EN
      OP_MADD:  res = {HI, LO} + prod_s;
      OP_MADDU: res = {HI, LO} + prod_u;
      OP_MSUB:  res = {HI, LO} - prod_s;
      OP_MSUBU: res = {HI, LO} - prod_u;
`endif
      default: ;
    endcase
  end

  // Architectural HI/LO: written by the commit edge or by an idle-state MTHI/MTLO.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      HI <= 32'd0;
      LO <= 32'd0;
    end else if (commit) begin
      HI <= res[63:32];
      LO <= res[31:0];
    end else if (state == S_IDLE && Start) begin
      if (Op == OP_MTHI) HI <= A;
      if (Op == OP_MTLO) LO <= A;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: a scoreboard queue holds the expected
// {HI,LO} and busy length of each accepted op, popped when Busy drops.
module tb_muldiv_unit;

  localparam int MUL = 5;
  localparam int DIV = 10;

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MTHI  = 4'd4;
  localparam logic [3:0] OP_MTLO  = 4'd5;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        Start = 1'b0;
  logic [3:0]  Op = 4'd0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        Busy, StallReq;
  logic [31:0] HI, LO;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;

  muldiv_unit #(.MUL_CYCLES(MUL), .DIV_CYCLES(DIV)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .A(A), .B(B),
    .Busy(Busy), .StallReq(StallReq), .HI(HI), .LO(LO)
  );

  always #5 Clk = ~Clk;

  // Reference multiply using 64-bit integer arithmetic.
  function automatic logic [63:0] ref_mul(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb_;
    if (sgn) begin
      sa  = longint'($signed(a));
      sb_ = longint'($signed(b));
    end else begin
      sa  = longint'({32'd0, a});
      sb_ = longint'({32'd0, b});
    end
    return 64'(sa * sb_);
  endfunction

  // Reference divide via magnitudes and sign fix-up; returns {rem, quot}.
  function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ua, ub, q, r;
    bit na, nb;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    na = sgn && a[31];
    nb = sgn && b[31];
    ua = na ? -a : a;
    ub = nb ? -b : b;
    q  = ua / ub;
    r  = ua % ub;
    if (na ^ nb) q = -q;
    if (na)      r = -r;
    return {r, q};
  endfunction

  // Present a request; caller is at a negedge.
  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1;
    Op    = op;
    A     = a;
    B     = b;
  endtask

  // Let the request be sampled, then drop Start and scramble operands.
  task automatic clock_in();
    @(posedge Clk);
    #1;
    Start = 1'b0;
    A     = $urandom;
    B     = $urandom;
  endtask

  task automatic push(input logic [63:0] hilo, input int cycles);
    exp_t e;
    e.hi = hilo[63:32];
    e.lo = hilo[31:0];
    e.cycles = cycles;
    sb.push_back(e);
  endtask

  // Count Busy cycles until commit, then pop and compare against the scoreboard.
  task automatic wait_commit(input string name);
    exp_t        e;
    int          n;
    logic [31:0] h0, l0;
    bit          moved;
    h0 = HI; l0 = LO; n = 0; moved = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge Clk);
      if (!Busy) break;
      n++;
      if (HI !== h0 || LO !== l0) moved = 1;
    end
    if (sb.size() == 0) begin
      n_total++;
      $display("FAIL %s scoreboard: no expected entry", name);
      return;
    end
    e = sb.pop_front();
    n_total++;
    if (n !== e.cycles) $display("FAIL %s busy_cycles: got %0d want %0d", name, n, e.cycles);
    else n_pass++;
    n_total++;
    if (moved) $display("FAIL %s hold: HI/LO changed during RUN", name);
    else n_pass++;
    n_total++;
    if (HI !== e.hi) $display("FAIL %s HI: got %h want %h", name, HI, e.hi);
    else n_pass++;
    n_total++;
    if (LO !== e.lo) $display("FAIL %s LO: got %h want %h", name, LO, e.lo);
    else n_pass++;
  endtask

  task automatic test_reset();
    #2;
    n_total++;
    if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0 || StallReq !== 1'b0)
      $display("FAIL reset: Busy=%b StallReq=%b HI=%h LO=%h want 0/0/0/0", Busy, StallReq, HI, LO);
    else n_pass++;
    @(negedge Clk);
    Rst = 1'b0;
  endtask

  task automatic test_mult();
    logic [31:0] ra, rb;
    @(negedge Clk);
    drive(OP_MULT, 32'hFFFF_FFFD, 32'd7);
    #1;
    n_total++;
    if (StallReq !== 1'b1) $display("FAIL mult stallreq: got %b want 1", StallReq);
    else n_pass++;
    push({32'hFFFF_FFFF, 32'hFFFF_FFEB}, MUL);
    clock_in();
    wait_commit("mult");
    drive(OP_MULTU, 32'hFFFF_FFFD, 32'd7);
    push({32'd6, 32'hFFFF_FFEB}, MUL);
    clock_in();
    wait_commit("multu");
    ra = $urandom; rb = $urandom;
    drive(OP_MULT, ra, rb);
    push(ref_mul(1'b1, ra, rb), MUL);
    clock_in();
    wait_commit("mult_rand");
    ra = $urandom; rb = $urandom;
    drive(OP_MULTU, ra, rb);
    push(ref_mul(1'b0, ra, rb), MUL);
    clock_in();
    wait_commit("multu_rand");
  endtask

  task automatic test_div();
    drive(OP_DIVU, 32'd100, 32'd7);
    #1;
    n_total++;
    if (StallReq !== 1'b1) $display("FAIL div stallreq: got %b want 1", StallReq);
    else n_pass++;
    push({32'd2, 32'd14}, DIV);
    clock_in();
    wait_commit("divu");
    drive(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    push({32'hFFFF_FFFF, 32'hFFFF_FFFD}, DIV);
    clock_in();
    wait_commit("div_neg");
    drive(OP_DIV, 32'd5, 32'd0);
    push({32'd5, 32'hFFFF_FFFF}, DIV);
    clock_in();
    wait_commit("div_zero");
    drive(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    push({32'd0, 32'h8000_0000}, DIV);
    clock_in();
    wait_commit("div_ovf");
    drive(OP_DIV, 32'd100, 32'hFFFF_FFF9);
    push(ref_div(1'b1, 32'd100, 32'hFFFF_FFF9), DIV);
    clock_in();
    wait_commit("div_negdivisor");
    drive(OP_DIVU, 32'hFFFF_FFF0, 32'd3);
    push(ref_div(1'b0, 32'hFFFF_FFF0, 32'd3), DIV);
    clock_in();
    wait_commit("divu_big");
  endtask

  task automatic test_mthi_mtlo();
    logic [31:0] lo_before;
    drive(OP_MTHI, 32'h1234_5678, 32'd0);
    #1;
    n_total++;
    if (StallReq !== 1'b0) $display("FAIL mthi stallreq: got %b want 0", StallReq);
    else n_pass++;
    clock_in();
    n_total++;
    if (HI !== 32'h1234_5678 || Busy !== 1'b0)
      $display("FAIL mthi: HI=%h Busy=%b want 12345678/0", HI, Busy);
    else n_pass++;
    @(negedge Clk);
    drive(OP_MULT, 32'd2, 32'd3);
    push({32'd0, 32'd6}, MUL - 1);
    clock_in();
    lo_before = LO;
    @(negedge Clk);
    drive(OP_MTLO, 32'hDEAD_BEEF, 32'd0);
    clock_in();
    n_total++;
    if (LO !== lo_before || Busy !== 1'b1)
      $display("FAIL mtlo_busy: LO=%h Busy=%b want %h/1", LO, Busy, lo_before);
    else n_pass++;
    wait_commit("mult_after_mtlo");
  endtask

  task automatic test_back_to_back();
    drive(OP_MULT, 32'd6, 32'd7);
    push({32'd0, 32'd42}, MUL - 1);
    clock_in();
    @(negedge Clk);
    drive(OP_MULT, 32'd100, 32'd100);
    clock_in();
    wait_commit("ignore_second");
    // Busy just read 0 on this cycle: start the next op immediately.
    drive(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    push({32'hFFFF_FFFE, 32'd1}, MUL);
    clock_in();
    wait_commit("b2b_multu");
    drive(OP_DIVU, 32'd1000, 32'd7);
    push({32'd6, 32'd142}, DIV);
    clock_in();
    wait_commit("b2b_divu");
  endtask

  task automatic test_reset_mid();
    drive(OP_DIV, 32'd1000, 32'd3);
    clock_in();
    repeat (4) @(negedge Clk);
    #1 Rst = 1'b1;
    #1;
    n_total++;
    if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0)
      $display("FAIL reset_mid: Busy=%b HI=%h LO=%h want 0/0/0", Busy, HI, LO);
    else n_pass++;
    @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
    drive(OP_MULT, 32'd3, 32'd4);
    push({32'd0, 32'd12}, MUL);
    clock_in();
    wait_commit("mult_after_reset");
  endtask

  task automatic test_madd();
`ifdef MULDIV_MADD_EN
    drive(OP_MTHI, 32'd0, 32'd0);
    clock_in();
    @(negedge Clk);
    drive(OP_MTLO, 32'hFFFF_FFFF, 32'd0);
    clock_in();
    @(negedge Clk);
    drive(4'd7, 32'd1, 32'd1);
    push({32'd1, 32'd0}, MUL);
    clock_in();
    wait_commit("maddu");
    drive(OP_MTHI, 32'd0, 32'd0);
    clock_in();
    @(negedge Clk);
    drive(OP_MTLO, 32'd0, 32'd0);
    clock_in();
    @(negedge Clk);
    drive(4'd8, 32'd2, 32'd3);
    push({32'hFFFF_FFFF, 32'hFFFF_FFFA}, MUL);
    clock_in();
    wait_commit("msub");
`else
    logic [31:0] h0, l0;
    h0 = HI; l0 = LO;
    drive(4'd6, 32'd9, 32'd9);
    #1;
    n_total++;
    if (StallReq !== 1'b0) $display("FAIL madd_off stallreq: got %b want 0", StallReq);
    else n_pass++;
    clock_in();
    @(negedge Clk);
    n_total++;
    if (Busy !== 1'b0 || HI !== h0 || LO !== l0)
      $display("FAIL madd_off: Busy=%b HI=%h LO=%h want 0/%h/%h", Busy, HI, LO, h0, l0);
    else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mthi_mtlo();
    test_back_to_back();
    test_reset_mid();
    test_madd();
    n_total++;
    if (sb.size() != 0) $display("FAIL scoreboard_drain: %0d entries left want 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
